// File: rtl/riscv_icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package riscv_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, REPLAY} icache_st_t;

  localparam int DATA_W   = 32;
  localparam int OFFSET_W = 2;

  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int word_width(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int tag_width(input int addr_w, input int lines, input int wpl);
    return addr_w - $clog2(lines) - $clog2(wpl) - OFFSET_W;
  endfunction

endpackage

// File: rtl/riscv_icache_ram.sv
// Synchronous-read data and tag arrays with one write port each, shaped for block RAM.
module riscv_icache_ram #(
  parameter int IDX_W  = 6,
  parameter int WORD_W = 2,
  parameter int TAG_W  = 22
) (
  input  logic              clk_i,
  input  logic              rd_en_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [WORD_W-1:0] rd_word_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [WORD_W-1:0] wr_word_i,
  input  logic [31:0]       wr_data_i,
  input  logic              tag_we_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic [31:0]       rd_data_o,
  output logic [TAG_W-1:0]  rd_tag_o
);

  logic [31:0]      data_mem [2**(IDX_W+WORD_W)];
  logic [TAG_W-1:0] tag_mem  [2**IDX_W];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) data_mem[{wr_idx_i, wr_word_i}] <= wr_data_i;
    if (tag_we_i) tag_mem[wr_idx_i] <= tag_i;
    if (rd_en_i) begin
      rd_data_o <= data_mem[{rd_idx_i, rd_word_i}];
      rd_tag_o  <= tag_mem[rd_idx_i];
    end
  end

endmodule

// File: rtl/riscv_icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, word-serial refill, replay.
// state  | meaning
// IDLE   | accepting lookups; a pending lookup resolves to hit or miss
// REFILL | fetching the missed line one word per mem_ack_i
// REPLAY | re-reading the held address so the next cycle is a hit
module riscv_icache
  import riscv_pkg::*;
#(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_ren_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [31:0]       cpu_data_o,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_data_i,
  input  logic              en_eval_regs,
  input  logic              rst_eval_regs,
  output logic [63:0]       hit_counter_o,
  output logic [63:0]       miss_counter_o
);

  localparam int IB = index_width(LINES);
  localparam int WB = word_width(WORDS_PER_LINE);
  localparam int TW = tag_width(ADDR_W, LINES, WORDS_PER_LINE);

  icache_st_t          state_q;
  logic [ADDR_W-3:0]   addr_q;
  logic                lookup_q;
  logic [WB-1:0]       beat_q;
  logic                flush_pend_q;
  logic [LINES-1:0]    valid_q;
  logic [31:0]         data_q;
  logic [63:0]         hit_cnt_q, miss_cnt_q;

  logic [WB-1:0] q_word, c_word, rd_word;
  logic [IB-1:0] q_idx, c_idx, rd_idx;
  logic [TW-1:0] q_tag, ram_rtag;
  logic [31:0]   ram_rdata;
  logic hit, miss, accept, rd_en, wr_en, last_beat;
  logic unused_addr_bits;

  assign q_word = addr_q[WB-1:0];
  assign q_idx  = addr_q[IB+WB-1:WB];
  assign q_tag  = addr_q[ADDR_W-3:IB+WB];
  assign c_word = cpu_addr_i[WB+1:2];
  assign c_idx  = cpu_addr_i[IB+WB+1:WB+2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit    = (state_q == IDLE) && lookup_q && valid_q[q_idx] && (ram_rtag == q_tag);
  assign miss   = (state_q == IDLE) && lookup_q && !hit;
  assign stall_o = (state_q != IDLE) || miss;
  assign accept = (state_q == IDLE) && !miss && cpu_ren_i;

  assign rd_en   = accept || (state_q == REPLAY);
  assign rd_idx  = (state_q == REPLAY) ? q_idx : c_idx;
  assign rd_word = (state_q == REPLAY) ? q_word : c_word;
  assign wr_en     = (state_q == REFILL) && mem_ack_i;
  assign last_beat = wr_en && (beat_q == WB'(WORDS_PER_LINE - 1));

  // Held word is shown whenever no fresh hit is being delivered.
  assign cpu_data_o = hit ? ram_rdata : data_q;
  assign mem_req_o  = (state_q == REFILL);
  assign mem_addr_o = (state_q == REFILL) ? {q_tag, q_idx, beat_q, 2'b00} : '0;
  assign hit_counter_o  = hit_cnt_q;
  assign miss_counter_o = miss_cnt_q;

  riscv_icache_ram #(
    .IDX_W  (IB),
    .WORD_W (WB),
    .TAG_W  (TW)
  ) u_ram (
    .clk_i     (clk_i),
    .rd_en_i   (rd_en),
    .rd_idx_i  (rd_idx),
    .rd_word_i (rd_word),
    .wr_en_i   (wr_en),
    .wr_idx_i  (q_idx),
    .wr_word_i (beat_q),
    .wr_data_i (mem_data_i),
    .tag_we_i  (last_beat),
    .tag_i     (q_tag),
    .rd_data_o (ram_rdata),
    .rd_tag_o  (ram_rtag)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      lookup_q     <= 1'b0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      data_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A deferred flush lands only after the replay hit has been delivered.
          if (flush_i || flush_pend_q) valid_q <= '0;
          flush_pend_q <= 1'b0;
          if (hit) data_q <= ram_rdata;
          if (miss) begin
            state_q  <= REFILL;
            beat_q   <= '0;
            lookup_q <= 1'b0;
          end else if (cpu_ren_i) begin
            addr_q   <= cpu_addr_i[ADDR_W-1:2];
            lookup_q <= 1'b1;
          end else begin
            lookup_q <= 1'b0;
          end
        end
        REFILL: begin
          if (flush_i) flush_pend_q <= 1'b1;
          if (mem_ack_i) begin
            beat_q <= beat_q + WB'(1);
            if (last_beat) begin
              valid_q[q_idx] <= 1'b1;
              state_q        <= REPLAY;
            end
          end
        end
        REPLAY: begin
          if (flush_i) flush_pend_q <= 1'b1;
          lookup_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || rst_eval_regs) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (en_eval_regs) begin
      if (hit)  hit_cnt_q  <= hit_cnt_q + 64'd1;
      if (miss) miss_cnt_q <= miss_cnt_q + 64'd1;
    end
  end

endmodule

// File: tb/tb_riscv_icache.sv
// Scoreboard bench for riscv_icache: directed reads, a word-serial memory responder, counter checks.
module tb_riscv_icache;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cpu_ren_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_o;
  logic        stall_o;
  logic        flush_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic        en_eval_regs = 1'b1;
  logic        rst_eval_regs = 1'b0;
  logic [63:0] hit_counter_o, miss_counter_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_base = '0;
  int          exp_beat = 0;
  int          ack_period = 1;

  riscv_icache dut (
    .clk_i(clk_i), .rst_i(rst_i), .cpu_ren_i(cpu_ren_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_o(cpu_data_o), .stall_o(stall_o), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .en_eval_regs(en_eval_regs), .rst_eval_regs(rst_eval_regs),
    .hit_counter_o(hit_counter_o), .miss_counter_o(miss_counter_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a >= 32'h2800 && a <= 32'h280C) return 32'h11 * ((a - 32'h2800) / 4 + 1);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory side: acks every ack_period-th requesting cycle, checks beat addresses.
  always @(negedge clk_i) begin
    static int cyc = 0;
    if (mem_req_o) begin
      chk("mem_addr", 64'(mem_addr_o), 64'(exp_base + 32'(exp_beat * 4)));
      cyc++;
      if (cyc % ack_period == 0) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_model(exp_base + 32'(exp_beat * 4));
        exp_beat++;
      end else begin
        mem_ack_i  = 1'b0;
        mem_data_i = 32'hDEAD_BEEF;
      end
    end else begin
      cyc = 0;
      exp_beat = 0;
      mem_ack_i  = 1'b0;
      mem_data_i = 32'hDEAD_BEEF;
    end
  end

  // Monitor: the first unstalled cycle after an accepted read carries its data.
  always @(negedge clk_i) begin
    logic [31:0] e;
    if (exp_q.size() > 0 && !stall_o) begin
      e = exp_q.pop_front();
      chk("cpu_data", 64'(cpu_data_o), 64'(e));
    end
  end

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    bit done = 0;
    cpu_addr_i = a;
    cpu_ren_i  = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!stall_o) begin
        @(posedge clk_i);
        exp_q.push_back(e);
        done = 1;
      end else begin
        @(posedge clk_i);
      end
      #1;
    end
    cpu_ren_i = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL rd_accept addr=%h never accepted", a);
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk_i); #1;
      if (exp_q.size() == 0 && !stall_o) done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL wait_idle timeout pending=%0d", exp_q.size());
    end
  endtask

  task automatic wait_beat(input int n);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk_i); #1;
      if (mem_req_o && exp_beat >= n) done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL wait_beat timeout beat=%0d", exp_beat);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [63:0] h, input logic [63:0] m);
    chk({name, "_hit"}, hit_counter_o, h);
    chk({name, "_miss"}, miss_counter_o, m);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_data", 64'(cpu_data_o), 64'h0);
    chk("rst_stall", 64'(stall_o), 64'h0);
    chk("rst_req", 64'(mem_req_o), 64'h0);
    chk("rst_maddr", 64'(mem_addr_o), 64'h0);
    chk_cnt("rst", 0, 0);

    // 1: cold miss
    exp_base = 32'h2800; ack_period = 1;
    rd(32'h2800, 32'h11);
    chk("t1_stall", 64'(stall_o), 64'h1);
    wait_idle();
    chk_cnt("t1", 1, 1);

    // 2: back-to-back hits
    rd(32'h2804, 32'h22);
    chk("t2_stall_a", 64'(stall_o), 64'h0);
    rd(32'h2808, 32'h33);
    chk("t2_stall_b", 64'(stall_o), 64'h0);
    wait_idle();
    chk_cnt("t2", 3, 1);

    // 3: wait states
    exp_base = 32'h3050; ack_period = 3;
    rd(32'h3058, 32'hA5A5_3058);
    wait_idle();
    chk_cnt("t3", 4, 2);

    // 4: conflict eviction
    exp_base = 32'h2C00; ack_period = 1;
    rd(32'h2C04, 32'hA5A5_2C04);
    wait_idle();
    exp_base = 32'h2800;
    rd(32'h2800, 32'h11);
    wait_idle();
    chk_cnt("t4", 6, 4);

    // 5: flush during refill
    exp_base = 32'h4000; ack_period = 2;
    rd(32'h4008, 32'hA5A5_4008);
    wait_beat(1);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    wait_idle();
    chk_cnt("t5a", 7, 5);
    rd(32'h4008, 32'hA5A5_4008);
    wait_idle();
    chk_cnt("t5b", 8, 6);

    // 6: reset mid-refill
    exp_base = 32'h5000; ack_period = 1;
    rd(32'h5004, 32'hA5A5_5004);
    wait_beat(2);
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("t6_req", 64'(mem_req_o), 64'h0);
    chk("t6_stall", 64'(stall_o), 64'h0);
    chk("t6_data", 64'(cpu_data_o), 64'h0);
    chk_cnt("t6rst", 0, 0);
    @(posedge clk_i); #1;
    rd(32'h5004, 32'hA5A5_5004);
    wait_idle();
    chk_cnt("t6", 1, 1);

    // counter enable and clear
    en_eval_regs = 1'b0;
    rd(32'h5000, 32'hA5A5_5000);
    wait_idle();
    chk_cnt("en_off", 1, 1);
    en_eval_regs = 1'b1;
    rst_eval_regs = 1'b1;
    @(posedge clk_i); #1;
    rst_eval_regs = 1'b0;
    chk_cnt("clr", 0, 0);

    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
